// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one external 8:1 single-bit mux among eight requesters.
// Drives the registered mux select and samples the mux output one cycle later.
module mux8_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       mux_out,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       out_bit,
    output logic       out_valid
);

    localparam int unsigned N     = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [SEL_W-1:0]   sel_n;
    logic [N-1:0]       gnt_n;
    logic               busy_n;
    logic [SEL_W-1:0]   ptr, ptr_n;
    logic [CNT_W-1:0]   hold_cnt, hold_n;
    logic [SEL_W-1:0]   winner;
    logic [N-1:0]       others;
    logic               at_max;

    // First set bit of r scanning upward from start, wrapping 7->0.
    function automatic logic [SEL_W-1:0] scan_from(input logic [N-1:0] r,
                                                   input logic [SEL_W-1:0] start);
        logic [SEL_W-1:0] idx;
        scan_from = start;
        for (int i = N - 1; i >= 0; i--) begin
            idx = start + SEL_W'(i);
            if (r[idx]) scan_from = idx;
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            gnt       <= gnt_n;
            busy      <= busy_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
            out_bit   <= mux_out;
            out_valid <= |gnt;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        gnt_n   = gnt;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        winner  = '0;
        others  = req & ~(N'(1) << sel);
        at_max  = (hold_cnt == CNT_W'(MAX_HOLD));

        case (state)
            IDLE: begin
                if (req != '0) begin
                    winner  = scan_from(req, ptr);
                    state_n = GRANT;
                    sel_n   = winner;
                    gnt_n   = N'(1) << winner;
                    hold_n  = CNT_W'(1);
                end
            end
            GRANT: begin
                // Voluntary release wins over forced rotation; both advance ptr the same way.
                if (!req[sel] || (at_max && others != '0)) begin
                    ptr_n = sel + SEL_W'(1);
                    if (others != '0) begin
                        winner = scan_from(others, sel + SEL_W'(1));
                        sel_n  = winner;
                        gnt_n  = N'(1) << winner;
                        hold_n = CNT_W'(1);
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        hold_n  = '0;
                    end
                end else if (!at_max) begin
                    hold_n = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase

        busy_n = (state_n == GRANT);
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Randomized and directed bench for mux8_rr_arbiter against a queue-free integer model.
// Two instances run side by side: MAX_HOLD=4 and MAX_HOLD=1.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic [7:0] a   = '0;

    logic [2:0] sel0, sel1;
    logic [7:0] gnt0, gnt1;
    logic       busy0, busy1, ob0, ob1, ov0, ov1;
    logic       mux_out0, mux_out1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state per instance (owner -1 means nobody granted).
    int   m_own[2];
    int   m_ptr[2];
    int   m_hold[2];
    int   m_sel[2];
    logic m_ob[2];
    logic m_ov[2];
    int   mh[2];

    assign mux_out0 = a[sel0];
    assign mux_out1 = a[sel1];

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .mux_out(mux_out0),
        .sel(sel0), .gnt(gnt0), .busy(busy0), .out_bit(ob0), .out_valid(ov0)
    );

    mux8_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .req(req), .mux_out(mux_out1),
        .sel(sel1), .gnt(gnt1), .busy(busy1), .out_bit(ob1), .out_valid(ov1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++) begin
            if (r[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1; m_ptr[k] = 0; m_hold[k] = 0; m_sel[k] = 0;
            m_ob[k] = 1'b0; m_ov[k] = 1'b0;
        end
    endtask

    // One clock edge of the arbitration rules, using pre-edge req and a.
    task automatic model_step();
        logic [7:0] rest;
        int o, w;
        for (int k = 0; k < 2; k++) begin
            m_ob[k] = a[m_sel[k]];
            m_ov[k] = (m_own[k] >= 0);
            if (m_own[k] < 0) begin
                if (req != 8'h00) begin
                    w = first_from(req, m_ptr[k]);
                    m_own[k] = w; m_sel[k] = w; m_hold[k] = 1;
                end
            end else begin
                o = m_own[k];
                rest = req;
                rest[o] = 1'b0;
                if (!req[o] || (m_hold[k] == mh[k] && rest != 8'h00)) begin
                    m_ptr[k] = (o + 1) % 8;
                    if (rest != 8'h00) begin
                        w = first_from(rest, m_ptr[k]);
                        m_own[k] = w; m_sel[k] = w; m_hold[k] = 1;
                    end else begin
                        m_own[k] = -1;
                    end
                end else if (m_hold[k] < mh[k]) begin
                    m_hold[k]++;
                end
            end
        end
    endtask

    task automatic compare_inst(input int k, input logic [7:0] g, input logic [2:0] s,
                                input logic b, input logic ob, input logic ov);
        logic [7:0] eg;
        eg = (m_own[k] < 0) ? 8'h00 : (8'h01 << m_own[k]);
        check($sformatf("gnt%0d", k), 32'(g), 32'(eg));
        check($sformatf("sel%0d", k), 32'(s), 32'(m_sel[k]));
        check($sformatf("busy%0d", k), 32'(b), 32'(m_own[k] >= 0));
        check($sformatf("out_valid%0d", k), 32'(ov), 32'(m_ov[k]));
        check($sformatf("out_bit%0d", k), 32'(ob), 32'(m_ob[k]));
    endtask

    task automatic cycle(input logic [7:0] r, input logic [7:0] d);
        @(negedge clk);
        req = r;
        a   = d;
        @(posedge clk);
        model_step();
        #1;
        compare_inst(0, gnt0, sel0, busy0, ob0, ov0);
        compare_inst(1, gnt1, sel1, busy1, ob1, ov1);
    endtask

    task automatic sync_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic exp_seq[8];
    logic [7:0] rr;

    initial begin
        mh[0] = 4;
        mh[1] = 1;
        exp_seq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_gnt", 32'(gnt0), 32'h0);
        check("reset_busy", 32'(busy0), 32'h0);
        rst = 1'b0;

        // Data tracking on the MAX_HOLD=1 instance, all requesting.
        for (int i = 1; i <= 9; i++) begin
            cycle(8'hFF, 8'b1010_0110);
            if (i >= 2) begin
                check("track_bit", 32'(ob1), 32'(exp_seq[i - 2]));
                check("track_valid", 32'(ov1), 32'h1);
            end
        end

        // Single requester, never preempted, then drop.
        sync_reset();
        for (int i = 1; i <= 10; i++) begin
            cycle(8'h04, 8'h04);
            check("single_gnt", 32'(gnt0), 32'h04);
            if (i >= 2) check("single_bit", 32'(ob0), 32'h1);
        end
        cycle(8'h00, 8'h04);
        check("drop_gnt", 32'(gnt0), 32'h0);
        check("drop_busy", 32'(busy0), 32'h0);

        // Round robin with everyone requesting: no gnt=0 bubble.
        sync_reset();
        for (int i = 0; i < 36; i++) begin
            cycle(8'hFF, 8'h5A);
            check("rr_no_bubble", 32'(gnt0 != 8'h00), 32'h1);
            check("rr_owner", 32'(sel0), 32'((i / 4) % 8));
        end

        // Forced rotation: req[5] joins at hold 2, switch when hold reaches 4.
        sync_reset();
        cycle(8'h08, 8'h00);
        cycle(8'h08, 8'h00);
        cycle(8'h28, 8'h00);
        cycle(8'h28, 8'h00);
        check("forced_hold", 32'(gnt0), 32'h08);
        cycle(8'h28, 8'h00);
        check("forced_switch", 32'(gnt0), 32'h20);

        // Voluntary release: req[3] drops at hold 2, switch on next edge.
        sync_reset();
        cycle(8'h08, 8'h00);
        cycle(8'h08, 8'h00);
        cycle(8'h20, 8'h00);
        check("voluntary_switch", 32'(gnt0), 32'h20);

        // Pointer wrap after owner 7.
        sync_reset();
        cycle(8'h80, 8'h00);
        cycle(8'h80, 8'h00);
        cycle(8'h00, 8'h00);
        cycle(8'h81, 8'h00);
        check("wrap_to_0", 32'(gnt0), 32'h01);
        cycle(8'h00, 8'h00);
        cycle(8'h80, 8'h00);
        check("regrant_7", 32'(gnt0), 32'h80);

        // Randomized traffic with sticky requests.
        rr = 8'h00;
        for (int i = 0; i < 400; i++) begin
            rr = rr ^ 8'($urandom & $urandom & $urandom);
            cycle(rr, 8'($urandom));
        end

        // Asynchronous reset in the middle of a grant.
        cycle(8'hFF, 8'hFF);
        cycle(8'hFF, 8'hFF);
        #2;
        rst = 1'b1;
        #1;
        check("async_gnt", 32'(gnt0), 32'h0);
        check("async_sel", 32'(sel0), 32'h0);
        check("async_busy", 32'(busy0), 32'h0);
        check("async_valid", 32'(ov0), 32'h0);
        model_reset();
        @(negedge clk);
        req = 8'h00;
        rst = 1'b0;
        cycle(8'h10, 8'h00);
        check("post_reset_gnt", 32'(gnt0), 32'h10);
        check("post_reset_sel", 32'(sel0), 32'h4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
